// File: rtl/latency_ram.sv
// latency_ram: word-addressed RAM that holds each request in BUSY for LAT cycles,
// then serves it in a single ACCESS cycle; bad addresses park the FSM in ERROR.
module latency_ram #(
    parameter int LAT   = 2,
    parameter int DEPTH = 1024
) (
    input  logic        CLK,
    input  logic        nRST,
    input  logic        ramREN,
    input  logic        ramWEN,
    input  logic [31:0] ramaddr,
    input  logic [31:0] ramstore,
    output logic [31:0] ramload,
    output logic [1:0]  ramstate
);
    localparam int AW = DEPTH > 1 ? $clog2(DEPTH) : 1;
    localparam int CW = LAT > 1 ? $clog2(LAT) : 1;
    localparam logic [CW-1:0] CNT_INIT = CW'(LAT > 0 ? LAT - 1 : 0);
    localparam logic [31:0] DEPTH_W = 32'(DEPTH);

    typedef enum logic [1:0] {FREE, BUSY, ACCESS, ERROR} state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [31:0]   addr_q, data_q;
    logic          wr_q;
    logic          cap, req, bad;
    logic [AW-1:0] idx_q;
    logic [31:0]   mem [DEPTH];

    assign req   = ramREN | ramWEN;
    assign bad   = (|ramaddr[1:0]) || ({2'b00, ramaddr[31:2]} >= DEPTH_W);
    assign idx_q = addr_q[AW+1:2];

    always_ff @(posedge CLK) begin
        if (!nRST) begin
            state_q <= FREE;
            cnt_q   <= '0;
            addr_q  <= '0;
            wr_q    <= 1'b0;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (cap) begin
                addr_q <= ramaddr;
                wr_q   <= ramWEN;
                data_q <= ramstore;
            end
        end
    end

    // A restart in BUSY recaptures the request exactly like a fresh start from FREE.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        cap     = 1'b0;
        case (state_q)
            BUSY: begin
                if (!req) begin
                    state_d = FREE;
                end else if (bad) begin
                    state_d = ERROR;
                end else if (ramaddr != addr_q || ramWEN != wr_q) begin
                    cap   = 1'b1;
                    cnt_d = CNT_INIT;
                end else if (cnt_q == '0) begin
                    state_d = ACCESS;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            default: begin
                if (!req) begin
                    state_d = FREE;
                end else if (bad) begin
                    state_d = ERROR;
                end else begin
                    cap     = 1'b1;
                    cnt_d   = CNT_INIT;
                    state_d = LAT == 0 ? ACCESS : BUSY;
                end
            end
        endcase
    end

    // Commit happens on the edge that ends ACCESS; an asserted reset on that edge aborts it.
    always_ff @(posedge CLK) begin
        if (nRST && state_q == ACCESS && wr_q) mem[idx_q] <= data_q;
    end

    always_comb begin
        ramstate = state_q;
        ramload  = (state_q == ACCESS && !wr_q) ? mem[idx_q] : 32'h0000_0000;
    end
endmodule

// File: tb/tb_latency_ram.sv
// tb_latency_ram: directed checks of latency, restart, error, write priority and reset abort,
// using one LAT=2 instance and one LAT=0 instance.
module tb_latency_ram;
    localparam logic [1:0] FREE = 2'd0, BUSY = 2'd1, ACCESS = 2'd2, ERROR = 2'd3;

    logic        CLK = 1'b0, nRST = 1'b0;
    logic        ren = 1'b0, wen = 1'b0;
    logic [31:0] addr = '0, store = '0, load;
    logic [1:0]  st;
    logic        ren0 = 1'b0, wen0 = 1'b0;
    logic [31:0] addr0 = '0, store0 = '0, load0;
    logic [1:0]  st0;
    int          vectors = 0, errors = 0;

    always #5 CLK = ~CLK;

    latency_ram #(.LAT(2), .DEPTH(1024)) dut (
        .CLK(CLK), .nRST(nRST), .ramREN(ren), .ramWEN(wen), .ramaddr(addr),
        .ramstore(store), .ramload(load), .ramstate(st)
    );

    latency_ram #(.LAT(0), .DEPTH(1024)) dut0 (
        .CLK(CLK), .nRST(nRST), .ramREN(ren0), .ramWEN(wen0), .ramaddr(addr0),
        .ramstore(store0), .ramload(load0), .ramstate(st0)
    );

    task automatic tick;
        @(posedge CLK);
        #1;
    endtask

    task automatic drive(input logic r, input logic w, input logic [31:0] a, input logic [31:0] d);
        ren = r;
        wen = w;
        addr = a;
        store = d;
    endtask

    // Runs one full request on the LAT=2 instance and returns what ramload showed in ACCESS.
    task automatic xfer(input logic w, input logic [31:0] a, input logic [31:0] d,
                        output logic ok, output logic [31:0] data);
        drive(!w, w, a, d);
        ok = 1'b0;
        data = '0;
        for (int i = 0; i < 20 && !ok; i++) begin
            tick;
            if (st == ACCESS) begin
                ok = 1'b1;
                data = load;
            end
        end
        drive(1'b0, 1'b0, '0, '0);
        tick;
    endtask

    task automatic test_reset;
        nRST = 1'b0;
        drive(1'b1, 1'b1, 32'h10, 32'hFFFF_FFFF);
        tick;
        tick;
        vectors++;
        if (st !== FREE) begin errors++; $display("FAIL reset_state: got %0d expected %0d", st, FREE); end
        vectors++;
        if (load !== 32'h0) begin errors++; $display("FAIL reset_load: got %h expected 0", load); end
        vectors++;
        if (st0 !== FREE) begin errors++; $display("FAIL reset_state_lat0: got %0d expected %0d", st0, FREE); end
        nRST = 1'b1;
        drive(1'b0, 1'b0, '0, '0);
        tick;
        vectors++;
        if (st !== FREE) begin errors++; $display("FAIL idle_after_reset: got %0d expected %0d", st, FREE); end
    endtask

    task automatic test_write_read;
        drive(1'b0, 1'b1, 32'h10, 32'hDEAD_BEEF);
        for (int i = 0; i < 3; i++) begin
            tick;
            vectors++;
            if (st !== (i == 2 ? ACCESS : BUSY)) begin
                errors++;
                $display("FAIL write_seq[%0d]: got %0d expected %0d", i, st, (i == 2 ? ACCESS : BUSY));
            end
        end
        vectors++;
        if (load !== 32'h0) begin errors++; $display("FAIL write_load: got %h expected 0", load); end
        drive(1'b0, 1'b0, '0, '0);
        tick;
        vectors++;
        if (st !== FREE) begin errors++; $display("FAIL write_end: got %0d expected %0d", st, FREE); end
        drive(1'b1, 1'b0, 32'h10, '0);
        for (int i = 0; i < 3; i++) begin
            tick;
            vectors++;
            if (st !== (i == 2 ? ACCESS : BUSY)) begin
                errors++;
                $display("FAIL read_seq[%0d]: got %0d expected %0d", i, st, (i == 2 ? ACCESS : BUSY));
            end
            if (i < 2) begin
                vectors++;
                if (load !== 32'h0) begin errors++; $display("FAIL busy_load[%0d]: got %h expected 0", i, load); end
            end
        end
        vectors++;
        if (load !== 32'hDEAD_BEEF) begin errors++; $display("FAIL read_data: got %h expected deadbeef", load); end
        drive(1'b0, 1'b0, '0, '0);
        tick;
        vectors++;
        if (st !== FREE || load !== 32'h0) begin
            errors++;
            $display("FAIL read_end: got state %0d load %h expected 0 and 0", st, load);
        end
    endtask

    task automatic test_restart;
        logic ok;
        logic [31:0] d;
        xfer(1'b1, 32'h20, 32'h2020_2020, ok, d);
        xfer(1'b1, 32'h24, 32'h2424_2424, ok, d);
        drive(1'b1, 1'b0, 32'h20, '0);
        tick;
        vectors++;
        if (st !== BUSY) begin errors++; $display("FAIL restart_first: got %0d expected %0d", st, BUSY); end
        drive(1'b1, 1'b0, 32'h24, '0);
        for (int i = 0; i < 3; i++) begin
            tick;
            vectors++;
            if (st !== (i == 2 ? ACCESS : BUSY)) begin
                errors++;
                $display("FAIL restart_seq[%0d]: got %0d expected %0d", i, st, (i == 2 ? ACCESS : BUSY));
            end
        end
        vectors++;
        if (load !== 32'h2424_2424) begin errors++; $display("FAIL restart_data: got %h expected 24242424", load); end
        drive(1'b0, 1'b0, '0, '0);
        tick;
    endtask

    task automatic test_error;
        logic [31:0] bad_addr [2];
        bad_addr[0] = 32'h0000_0002;
        bad_addr[1] = 32'h0000_1000;
        for (int k = 0; k < 2; k++) begin
            drive(1'b1, 1'b0, bad_addr[k], '0);
            tick;
            vectors++;
            if (st !== ERROR || load !== 32'h0) begin
                errors++;
                $display("FAIL error_enter[%0d]: got state %0d load %h expected 3 and 0", k, st, load);
            end
            tick;
            vectors++;
            if (st !== ERROR) begin errors++; $display("FAIL error_hold[%0d]: got %0d expected %0d", k, st, ERROR); end
            drive(1'b0, 1'b0, '0, '0);
            tick;
            vectors++;
            if (st !== FREE) begin errors++; $display("FAIL error_exit[%0d]: got %0d expected %0d", k, st, FREE); end
        end
        drive(1'b1, 1'b0, 32'h2, '0);
        tick;
        drive(1'b1, 1'b0, 32'h10, '0);
        for (int i = 0; i < 3; i++) begin
            tick;
            vectors++;
            if (st !== (i == 2 ? ACCESS : BUSY)) begin
                errors++;
                $display("FAIL error_recover[%0d]: got %0d expected %0d", i, st, (i == 2 ? ACCESS : BUSY));
            end
        end
        vectors++;
        if (load !== 32'hDEAD_BEEF) begin errors++; $display("FAIL error_recover_data: got %h expected deadbeef", load); end
        drive(1'b0, 1'b0, '0, '0);
        tick;
    endtask

    task automatic test_write_priority;
        logic ok;
        logic [31:0] d;
        drive(1'b1, 1'b1, 32'h8, 32'h1234_5678);
        tick;
        tick;
        tick;
        vectors++;
        if (st !== ACCESS || load !== 32'h0) begin
            errors++;
            $display("FAIL prio_access: got state %0d load %h expected 2 and 0", st, load);
        end
        drive(1'b0, 1'b0, '0, '0);
        tick;
        xfer(1'b0, 32'h8, '0, ok, d);
        vectors++;
        if (!ok || d !== 32'h1234_5678) begin
            errors++;
            $display("FAIL prio_readback: got ok %0b data %h expected 1 and 12345678", ok, d);
        end
    endtask

    task automatic test_data_hold;
        logic ok;
        logic [31:0] d;
        drive(1'b0, 1'b1, 32'h40, 32'h1111_1111);
        tick;
        store = 32'h2222_2222;
        tick;
        tick;
        vectors++;
        if (st !== ACCESS) begin errors++; $display("FAIL hold_no_restart: got %0d expected %0d", st, ACCESS); end
        drive(1'b0, 1'b0, '0, '0);
        tick;
        xfer(1'b0, 32'h40, '0, ok, d);
        vectors++;
        if (!ok || d !== 32'h1111_1111) begin
            errors++;
            $display("FAIL hold_readback: got ok %0b data %h expected 1 and 11111111", ok, d);
        end
    endtask

    task automatic test_reset_abort;
        logic ok;
        logic [31:0] d;
        xfer(1'b1, 32'h30, 32'h1111_2222, ok, d);
        drive(1'b0, 1'b1, 32'h30, 32'hCAFE_F00D);
        tick;
        nRST = 1'b0;
        tick;
        vectors++;
        if (st !== FREE) begin errors++; $display("FAIL abort_busy_state: got %0d expected %0d", st, FREE); end
        nRST = 1'b1;
        drive(1'b0, 1'b0, '0, '0);
        tick;
        xfer(1'b0, 32'h30, '0, ok, d);
        vectors++;
        if (!ok || d !== 32'h1111_2222) begin
            errors++;
            $display("FAIL abort_busy_data: got ok %0b data %h expected 1 and 11112222", ok, d);
        end
        xfer(1'b1, 32'h34, 32'h3434_3434, ok, d);
        drive(1'b0, 1'b1, 32'h34, 32'hBAD0_BAD0);
        tick;
        tick;
        tick;
        vectors++;
        if (st !== ACCESS) begin errors++; $display("FAIL abort_access_reach: got %0d expected %0d", st, ACCESS); end
        nRST = 1'b0;
        tick;
        vectors++;
        if (st !== FREE) begin errors++; $display("FAIL abort_access_state: got %0d expected %0d", st, FREE); end
        nRST = 1'b1;
        drive(1'b0, 1'b0, '0, '0);
        tick;
        xfer(1'b0, 32'h34, '0, ok, d);
        vectors++;
        if (!ok || d !== 32'h3434_3434) begin
            errors++;
            $display("FAIL abort_access_data: got ok %0b data %h expected 1 and 34343434", ok, d);
        end
    endtask

    task automatic test_lat0;
        wen0 = 1'b1;
        addr0 = 32'h4;
        store0 = 32'h0404_0404;
        tick;
        vectors++;
        if (st0 !== ACCESS) begin errors++; $display("FAIL lat0_write: got %0d expected %0d", st0, ACCESS); end
        addr0 = 32'h8;
        store0 = 32'h0808_0808;
        tick;
        wen0 = 1'b0;
        tick;
        vectors++;
        if (st0 !== FREE) begin errors++; $display("FAIL lat0_idle: got %0d expected %0d", st0, FREE); end
        ren0 = 1'b1;
        addr0 = 32'h4;
        for (int i = 0; i < 3; i++) begin
            tick;
            vectors++;
            if (st0 !== ACCESS || load0 !== 32'h0404_0404) begin
                errors++;
                $display("FAIL lat0_read[%0d]: got state %0d load %h expected 2 and 04040404", i, st0, load0);
            end
        end
        addr0 = 32'h8;
        tick;
        vectors++;
        if (st0 !== ACCESS || load0 !== 32'h0808_0808) begin
            errors++;
            $display("FAIL lat0_switch: got state %0d load %h expected 2 and 08080808", st0, load0);
        end
        ren0 = 1'b0;
        tick;
        vectors++;
        if (st0 !== FREE || load0 !== 32'h0) begin
            errors++;
            $display("FAIL lat0_end: got state %0d load %h expected 0 and 0", st0, load0);
        end
    endtask

    initial begin
        test_reset;
        test_write_read;
        test_restart;
        test_error;
        test_write_priority;
        test_data_hold;
        test_reset_abort;
        test_lat0;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule
